// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage.
//   fetch_entry_t : queue entry layout {pc, word} at the default widths
//   redirect_e    : which redirect source (if any) owns the current cycle
//   words_of()    : instruction length in words (1, or 2 with an immediate)
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned INSTR_W_DEF    = 16;
  localparam int unsigned DEPTH_DEF      = 4;
  localparam logic [31:0] RESET_PC_DEF   = '0;
  localparam logic [31:0] INT_VECTOR_DEF = '0;
  localparam int unsigned IMM_BIT_DEF    = 0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] word;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_RESET,
    REDIR_INT,
    REDIR_JUMP
  } redirect_e;

  function automatic logic [1:0] words_of(input logic has_imm);
    return has_imm ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, word} entries.
//   clk, rst_ni    : clock, synchronous active-low reset
//   flush_i        : drop all entries (wins over push/pop)
//   push_i         : append one entry
//   push_pc_i/push_word_i : entry being appended
//   pop_cnt_i      : entries removed this cycle (0, 1 or 2)
//   head_pc_o/head_word_o : entry at the read pointer
//   nxt_word_o     : word of the entry after the head (wraps mod DEPTH)
//   count_o        : occupied entries
module fetch_fifo #(
  parameter  int unsigned ADDR_W  = 32,
  parameter  int unsigned INSTR_W = 16,
  parameter  int unsigned DEPTH   = 4,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  input  logic [INSTR_W-1:0] push_word_i,
  input  logic [1:0]         pop_cnt_i,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [INSTR_W-1:0] head_word_o,
  output logic [INSTR_W-1:0] nxt_word_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
  logic [INSTR_W-1:0] word_mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
  logic [CNT_W-1:0]   count_q, count_d;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt_i);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_cnt_i);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      pc_mem_q[wr_ptr_q]   <= push_pc_i;
      word_mem_q[wr_ptr_q] <= push_word_i;
    end
  end

  assign rd_nxt      = rd_ptr_q + PTR_W'(1);
  assign head_pc_o   = pc_mem_q[rd_ptr_q];
  assign head_word_o = word_mem_q[rd_ptr_q];
  assign nxt_word_o  = word_mem_q[rd_nxt];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC generation, registered instruction-memory requests and a
// DEPTH-entry prefetch queue that pairs opcode words with their immediate
// before handing bundles to decode over valid/ready.
//   clk, rst                 : clock, synchronous active-low reset
//   jump_valid, jump_target  : branch redirect
//   int_valid                : interrupt redirect to INT_VECTOR (beats jump)
//   imem_req, imem_addr      : memory read request, address = fetch PC
//   imem_rdata               : read data, one cycle after imem_req
//   out_valid, out_ready     : decode handshake
//   out_instr, out_imm, out_has_imm, out_pc, out_next_pc : decode bundle
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       INSTR_W    = INSTR_W_DEF,
  parameter int unsigned       DEPTH      = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(INT_VECTOR_DEF),
  parameter int unsigned       IMM_BIT    = IMM_BIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               int_valid,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_imm,
  output logic               out_has_imm,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_next_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d, tag_q, tag_d, redir_pc;
  logic               inflight_q, inflight_d;
  redirect_e          redir;
  logic               flush, push, req, fire, has_imm;
  logic [1:0]         pop_cnt;
  logic [CNT_W-1:0]   count, occ;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_word, nxt_word;

  always_comb begin
    redir    = REDIR_NONE;
    redir_pc = fetch_pc_q;
    if (!rst) begin
      redir    = REDIR_RESET;
      redir_pc = RESET_PC;
    end else if (int_valid) begin
      redir    = REDIR_INT;
      redir_pc = INT_VECTOR;
    end else if (jump_valid) begin
      redir    = REDIR_JUMP;
      redir_pc = jump_target;
    end
  end

  // Reset clears the queue through the FIFO's own reset; flush covers the rest.
  assign flush = (redir == REDIR_INT) || (redir == REDIR_JUMP);
  // A response arriving in a redirect cycle belongs to the old stream.
  assign push  = inflight_q && (redir == REDIR_NONE);
  // Counting the in-flight word reserves its slot before it lands.
  assign occ   = count + CNT_W'(inflight_q);
  assign req   = (redir == REDIR_NONE) && (occ < CNT_W'(DEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    if (redir != REDIR_NONE) begin
      fetch_pc_d = redir_pc;
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      inflight_d = 1'b1;
      tag_d      = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  fetch_fifo #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_pc_i   (tag_q),
    .push_word_i (imem_rdata),
    .pop_cnt_i   (pop_cnt),
    .head_pc_o   (head_pc),
    .head_word_o (head_word),
    .nxt_word_o  (nxt_word),
    .count_o     (count)
  );

  // A two-word head is held back until its immediate is also queued.
  assign has_imm     = head_word[IMM_BIT];
  assign out_valid   = rst && (has_imm ? (count >= CNT_W'(2)) : (count >= CNT_W'(1)));
  assign fire        = out_valid && out_ready;
  assign pop_cnt     = fire ? words_of(has_imm) : 2'd0;

  assign imem_req    = req;
  assign imem_addr   = fetch_pc_q;
  assign out_instr   = head_word;
  assign out_has_imm = has_imm;
  assign out_imm     = has_imm ? nxt_word : '0;
  assign out_pc      = head_pc;
  assign out_next_pc = head_pc + ADDR_W'(words_of(has_imm));

endmodule
